// File: rtl/mmio_stepper_ctrl_if.sv
// Data-memory bus bundle between the processor and the stepper responder.
// Latency: none (wires only); the responder registers dataOut/hit one cycle after addr.
// Backpressure: none; the bus is a fixed-timing strobe bus with no stall path.
//
// Signals:
//   wEn      write strobe from the processor
//   addr     word address (address_dmem[11:0])
//   dataIn   write data
//   dataOut  registered read data from the responder
//   hit      registered "this block owns the previous address"
interface mmio_stepper_ctrl_if;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        hit;

    modport master (output wEn, addr, dataIn, input dataOut, hit);
    modport slave  (input wEn, addr, dataIn, output dataOut, hit);
endinterface

// File: rtl/mmio_stepper_ctrl.sv
// Memory-mapped stepper-motor controller: CMD store starts an N-step move, STATUS load polls it.
// Latency: reads return one cycle after addr; step_out rises one cycle after dir_out updates.
// Backpressure: none; a CMD arriving while a move runs is dropped and flagged in overrun.
//
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   bus           slave side of the data-memory bus (wEn/addr/dataIn in, dataOut/hit out)
//   step_out      step pulse train, HALF_PERIOD cycles high then HALF_PERIOD low per step
//   dir_out       direction to the driver, 1 = forward
//   busy          high while a move is in progress
module mmio_stepper_ctrl #(
    parameter logic [11:0] BASE_ADDR   = 12'hF00,
    parameter int          HALF_PERIOD = 50000,
    parameter int          CNT_W       = 17
) (
    input  logic                 clock,
    input  logic                 reset,
    mmio_stepper_ctrl_if.slave   bus,
    output logic                 step_out,
    output logic                 dir_out,
    output logic                 busy
);

    localparam logic [11:0]      ADDR_CMD    = BASE_ADDR;
    localparam logic [11:0]      ADDR_STATUS = BASE_ADDR + 12'd1;
    localparam logic [11:0]      ADDR_ABORT  = BASE_ADDR + 12'd2;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      remaining;
    logic             overrun;

    logic        cmd_wr;
    logic        abort_wr;
    logic        cmd_dir;
    logic [15:0] cmd_steps;

    assign cmd_wr    = bus.wEn && (bus.addr == ADDR_CMD);
    assign abort_wr  = bus.wEn && (bus.addr == ADDR_ABORT);
    assign cmd_dir   = bus.dataIn[31];
    assign cmd_steps = bus.dataIn[15:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            remaining   <= '0;
            overrun     <= 1'b0;
            step_out    <= 1'b0;
            dir_out     <= 1'b0;
            busy        <= 1'b0;
            bus.dataOut <= '0;
            bus.hit     <= 1'b0;
        end else begin
            // Read path samples state before any write in this cycle takes effect.
            bus.hit <= (bus.addr == ADDR_CMD) || (bus.addr == ADDR_STATUS) ||
                       (bus.addr == ADDR_ABORT);
            if (bus.addr == ADDR_STATUS) begin
                bus.dataOut <= {busy, overrun, 14'b0, remaining};
            end else if (bus.addr == ADDR_CMD) begin
                bus.dataOut <= {dir_out, 15'b0, remaining};
            end else begin
                bus.dataOut <= '0;
            end

            if (abort_wr) begin
                // Abort wins over any phase progress; direction is deliberately kept.
                state     <= IDLE;
                cnt       <= '0;
                remaining <= '0;
                step_out  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        step_out <= 1'b0;
                        if (cmd_wr && (cmd_steps != 16'd0)) begin
                            dir_out   <= cmd_dir;
                            remaining <= cmd_steps;
                            busy      <= 1'b1;
                            overrun   <= 1'b0;
                            cnt       <= '0;
                            state     <= HIGH;
                        end
                    end
                    HIGH: begin
                        // step_out follows the state one cycle late, which gives the
                        // driver a full cycle of dir setup before the first rising edge.
                        step_out <= 1'b1;
                        if (cmd_wr) begin
                            overrun <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= LOW;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOW: begin
                        step_out <= 1'b0;
                        if (cmd_wr) begin
                            overrun <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            cnt       <= '0;
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= HIGH;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
